// File: rtl/spi_controller.sv
`timescale 1ns/1ps
// spi_controller: mode-0 SPI controller; sends TX_LENGTH bits LSB-first on COPI,
// then shifts RX_LENGTH bits in from CIPO, starting RX_OFFSET SCK edges after the last TX edge.
// Ports: clk, rst (synchronous, active-low) | start, tx_data -> request
//        busy, done, rx_data -> status/result | SCK, CS, COPI, CIPO -> serial bus
module spi_controller #(
   parameter int CLK_DIV   = 2,
   parameter int TX_LENGTH = 8,
   parameter int RX_LENGTH = 8,
   parameter int RX_OFFSET = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [TX_LENGTH-1:0] tx_data,
   output logic                 busy,
   output logic                 done,
   output logic [RX_LENGTH-1:0] rx_data,
   output logic                 SCK,
   output logic                 CS,
   output logic                 COPI,
   input  logic                 CIPO
);

   localparam int N        = TX_LENGTH + RX_OFFSET + RX_LENGTH - 1;
   localparam int CW       = $clog2(N + 1);
   localparam int DW       = $clog2(CLK_DIV + 1);
   localparam int FIRST_RX = TX_LENGTH + RX_OFFSET;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

   state_t               state;
   logic [DW-1:0]        div_cnt;
   logic [CW-1:0]        edge_cnt;
   logic [TX_LENGTH-1:0] tx_shift;
   logic [TX_LENGTH-1:0] tx_next;
   logic [RX_LENGTH-1:0] rx_shift;
   logic [RX_LENGTH-1:0] rx_next;
   logic                 phase_end;

   // Zeros shift in behind the TX word, so COPI falls to 0 once it is sent.
   always_comb begin
      tx_next = tx_shift >> 1;
      rx_next = rx_shift >> 1;
      rx_next[RX_LENGTH-1] = CIPO;
   end

   assign phase_end = (div_cnt == DW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         SCK      <= 1'b0;
         CS       <= 1'b1;
         COPI     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            if (start) begin
               state    <= SETUP;
               tx_shift <= tx_data;
               COPI     <= tx_data[0];
               CS       <= 1'b0;
               SCK      <= 1'b0;
               busy     <= 1'b1;
            end
         end else if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
            unique case (state)
               SETUP, LOW: begin
                  if (state == LOW && edge_cnt == CW'(N)) begin
                     state <= HOLD;
                  end else begin
                     // Rising edge number edge_cnt+1; CIPO is sampled on this edge.
                     state    <= HIGH;
                     SCK      <= 1'b1;
                     edge_cnt <= edge_cnt + 1'b1;
                     if (edge_cnt >= CW'(FIRST_RX - 1))
                        rx_shift <= rx_next;
                  end
               end
               HIGH: begin
                  state    <= LOW;
                  SCK      <= 1'b0;
                  tx_shift <= tx_next;
                  COPI     <= tx_next[0];
               end
               HOLD: begin
                  state <= GAP;
                  CS    <= 1'b1;
               end
               GAP: begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  rx_data <= rx_shift;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
// tb_spi_controller: frame-level model plus periphery model against two DUTs
// (CLK_DIV=2 checked every cycle, CLK_DIV=1 checked by directed literals).
module tb_spi_controller;

   localparam int D   = 2;
   localparam int TXL = 8;
   localparam int RXL = 8;
   localparam int OFF = 2;
   localparam int N   = TXL + OFF + RXL - 1;
   localparam int T   = (2 * N + 3) * D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, busy, done, sck, cs, copi, cipo;
   logic [7:0] tx_data, rx_data;
   logic       rst1, start1, busy1, done1, sck1, cs1, copi1;
   logic [7:0] tx1, rx1;

   int vec  = 0;
   int errs = 0;

   spi_controller #(.CLK_DIV(D), .TX_LENGTH(TXL), .RX_LENGTH(RXL), .RX_OFFSET(OFF)) u_dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
      .busy(busy), .done(done), .rx_data(rx_data),
      .SCK(sck), .CS(cs), .COPI(copi), .CIPO(cipo)
   );

   spi_controller #(.CLK_DIV(1), .TX_LENGTH(8), .RX_LENGTH(8), .RX_OFFSET(2)) u_dut1 (
      .clk(clk), .rst(rst1), .start(start1), .tx_data(tx1),
      .busy(busy1), .done(done1), .rx_data(rx1),
      .SCK(sck1), .CS(cs1), .COPI(copi1), .CIPO(1'b1)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Periphery: counts SCK rises per frame, captures COPI for the first TXL
   // rises, and presents its word on CIPO ahead of rises TXL+OFF .. N.
   logic [7:0] p_word = 8'h00;
   logic [7:0] p_lat  = 8'h00;
   logic [7:0] p_rcv  = 8'h00;
   int         p_rise = 0;

   always @(posedge sck or negedge cs) begin
      if (!sck) begin
         p_rise = 0;
         p_lat  = p_word;
         p_rcv  = 8'h00;
      end else begin
         if (p_rise < TXL) p_rcv[p_rise] = copi;
         p_rise++;
      end
   end

   always_comb begin
      int idx;
      idx  = p_rise - (TXL + OFF - 1);
      cipo = 1'b0;
      if (idx >= 0 && idx < RXL) cipo = p_lat[idx];
   end

   // Frame model: m_c counts cycles since the accepting edge.
   bit         m_on  = 0;
   bit         m_act = 0;
   bit         m_dn  = 0;
   int         m_c   = 0;
   logic [7:0] m_tx  = 8'h00;
   logic [7:0] m_word = 8'h00;
   logic [7:0] m_rx  = 8'h00;

   always @(posedge clk) begin
      m_dn = 0;
      if (!rst) begin
         m_act = 0;
         m_rx  = 8'h00;
         m_on  = 1;
      end else if (m_act) begin
         m_c++;
         if (m_c == T) begin
            m_act = 0;
            m_dn  = 1;
            m_rx  = m_word;
         end
      end else if (start) begin
         m_act  = 1;
         m_c    = 0;
         m_tx   = tx_data;
         m_word = p_word;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         int   ph, f;
         logic e_sck, e_cs, e_copi, e_busy, e_done;
         e_sck = 0; e_cs = 1; e_copi = 0; e_busy = 0; e_done = m_dn;
         if (m_act) begin
            ph     = m_c / D;
            e_sck  = (ph % 2 == 1) && (ph <= 2 * N - 1);
            e_cs   = (ph >= 2 * N + 2);
            f      = (ph <= 2 * N) ? ph / 2 : N;
            e_copi = (f < TXL) ? m_tx[f] : 1'b0;
            e_busy = 1;
         end
         chk("sck", sck, e_sck);
         chk("cs", cs, e_cs);
         chk("copi", copi, e_copi);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("rx_data", rx_data, m_rx);
         if (m_dn) chk("periph_rx", p_rcv, m_tx);
      end
   end

   int lat, dcnt, hi;

   task automatic xfer(input logic [7:0] tx, input logic [7:0] pw, input int inj);
      tx_data = tx;
      p_word  = pw;
      start   = 1'b1;
      @(posedge clk);
      lat = -1; dcnt = 0; hi = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            if (lat < 0) lat = i;
         end
         if (copi) hi++;
         start = (i == inj);
         if (i == inj) tx_data = 8'hFF;
      end
      start = 1'b0;
   endtask

   initial begin
      int run, gap, r1, r2, prev, h1, h2, k;
      rst = 0; start = 0; tx_data = 0; rst1 = 0; start1 = 0; tx1 = 0;
      repeat (3) @(negedge clk);
      chk("reset_cs", cs, 1'b1);
      chk("reset_sck", sck, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_rx", rx_data, 8'h00);
      chk("reset1_cs", cs1, 1'b1);
      chk("reset1_rx", rx1, 8'h00);

      // Basic frame, started on the very first edge out of reset.
      rst = 1; rst1 = 1;
      xfer(8'hA5, 8'h3C, -1);
      chk("basic_latency", 8'(lat), 8'd74);
      chk("basic_done_cnt", 8'(dcnt), 8'd1);
      chk("basic_copi_bits", p_rcv, 8'hA5);
      chk("basic_sck_rises", 8'(p_rise), 8'd17);
      chk("basic_rx", rx_data, 8'h3C);

      // Start pulsed mid-frame with different data must be ignored.
      xfer(8'h00, 8'h81, 20);
      chk("busy_done_cnt", 8'(dcnt), 8'd1);
      chk("busy_copi_high", 8'(hi), 8'd0);
      chk("busy_latency", 8'(lat), 8'd74);
      chk("busy_rx", rx_data, 8'h81);

      // Back-to-back: start held until the second frame drops CS.
      tx_data = 8'h5A; p_word = 8'h96; start = 1'b1;
      @(posedge clk);
      run = 0; gap = -1; r1 = -1; r2 = -1; dcnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 0) begin tx_data = 8'hC3; p_word = 8'h69; end
         if (cs) run++;
         else if (run > 0) begin
            if (gap < 0) gap = run;
            run = 0;
            start = 1'b0;
         end
         if (done) begin
            dcnt++;
            if (dcnt == 1) r1 = int'(rx_data); else r2 = int'(rx_data);
         end
      end
      start = 1'b0;
      // CS stays high through GAP plus the IDLE cycle that carries done.
      chk("b2b_cs_gap", 8'(gap), 8'(D + 1));
      chk("b2b_done_cnt", 8'(dcnt), 8'd2);
      chk("b2b_rx1", 8'(r1), 8'h96);
      chk("b2b_rx2", 8'(r2), 8'h69);

      // Reset while SCK is high after rising edge 5.
      tx_data = 8'h33; p_word = 8'h55; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (p_rise < 5 && k < 100) begin @(negedge clk); k++; end
      chk("rst_reach_edge5", 8'(p_rise), 8'd5);
      rst = 0;
      @(posedge clk); #1;
      chk("rst_mid_cs", cs, 1'b1);
      chk("rst_mid_sck", sck, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_rx", rx_data, 8'h00);
      @(negedge clk);
      rst = 1;
      dcnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("rst_no_done", 8'(dcnt), 8'd0);

      // Minimum divider instance, CIPO tied high.
      tx1 = 8'h01; start1 = 1'b1;
      @(posedge clk);
      lat = -1; prev = 0; h1 = -1; h2 = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (i == 0) chk("div1_copi_bit0", copi1, 1'b1);
         if (i == 2) chk("div1_copi_bit1", copi1, 1'b0);
         if (sck1 && !prev) begin
            if (h1 < 0) h1 = i; else if (h2 < 0) h2 = i;
         end
         prev = int'(sck1);
         if (done1 && lat < 0) lat = i;
      end
      chk("div1_latency", 8'(lat), 8'd37);
      chk("div1_sck_period", 8'(h2 - h1), 8'd2);
      chk("div1_rx", rx1, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
